hs_arbiter2: RTL and testbench

Clocked two-client arbiter for the four-phase req/ack handshake channels of the asynchronous pipeline. It merges two requesting stages onto one shared downstream resource, which is the complement of the two-way fork element. It synchronises the incoming handshake wires, grants one client at a time with round-robin fairness, and drives a one-hot select for the bundled-data mux. The selected client's four-phase handshake is passed through to the resource and its acknowledge is returned.

---
 rtl/hs_arbiter2_if.sv | 25 ++
 rtl/hs_arbiter2.sv | 128 ++++++++++++
 tb/tb_hs_arbiter2.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_arbiter2_if.sv
// Handshake bundle for the two-client arbiter: two four-phase client channels,
// one four-phase channel to the shared resource, the data-mux select and a
// busy flag. Signal names are seen from the arbiter's side.
interface hs_arbiter2_if;
  logic       req_in1_i;
  logic       req_in2_i;
  logic       ack_in1_o;
  logic       ack_in2_o;
  logic       req_out_o;
  logic       ack_out_i;
  logic [1:0] grant_o;
  logic       busy_o;

  // Arbiter side
  modport slave (
    input  req_in1_i, req_in2_i, ack_out_i,
    output ack_in1_o, ack_in2_o, req_out_o, grant_o, busy_o
  );

  // Environment side: clients plus shared resource
  modport master (
    output req_in1_i, req_in2_i, ack_out_i,
    input  ack_in1_o, ack_in2_o, req_out_o, grant_o, busy_o
  );
endinterface

// File: rtl/hs_arbiter2.sv
// Two-client round-robin arbiter for four-phase req/ack channels. Incoming
// handshake wires are synchronised, one client at a time is granted, the
// one-hot grant drives the bundled-data mux and the winner's handshake is
// relayed to the shared resource. Every output comes straight from a flop.
module hs_arbiter2 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  hs_arbiter2_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_HOLD,
    S_RTZ
  } state_t;

  logic [2:0] w_raw;
  logic       w_req1_s;
  logic       w_req2_s;
  logic       w_ack_s;
  logic       w_pick2;
  logic       w_win_req;

  state_t     r_state;
  logic [1:0] r_grant;
  logic       r_req_out;
  logic       r_ack1;
  logic       r_ack2;
  logic       r_busy;
  logic       r_ptr;      // 0: client 1 has priority on a tie, 1: client 2

  assign w_raw = {bus.ack_out_i, bus.req_in2_i, bus.req_in1_i};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign {w_ack_s, w_req2_s, w_req1_s} = w_raw;
    end else begin : g_sync
      logic [2:0] r_sync [SYNC_STAGES];

      // Shift the three asynchronous handshake wires through the flop chain
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= 3'b000;
          end
        end else begin
          r_sync[0] <= w_raw;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign {w_ack_s, w_req2_s, w_req1_s} = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Client 2 wins when it is the only requester or when both ask and it holds priority
  assign w_pick2   = w_req2_s & (~w_req1_s | r_ptr);
  // Only the granted client's request is watched once the transaction is running
  assign w_win_req = r_grant[1] ? w_req2_s : w_req1_s;

  // Handshake sequencer; all outputs are updated here so they stay glitch-free
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'b00;
      r_req_out <= 1'b0;
      r_ack1    <= 1'b0;
      r_ack2    <= 1'b0;
      r_busy    <= 1'b0;
      r_ptr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req1_s || w_req2_s) begin
            r_grant <= w_pick2 ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          // One cycle of mux setup before the resource sees a request
          r_req_out <= 1'b1;
          r_state   <= S_REQ;
        end
        S_REQ: begin
          if (w_ack_s) begin
            r_ack1  <= r_grant[0];
            r_ack2  <= r_grant[1];
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // An early-dropped request falls straight through on the first cycle
          if (!w_win_req) begin
            r_req_out <= 1'b0;
            r_state   <= S_RTZ;
          end
        end
        S_RTZ: begin
          if (!w_ack_s) begin
            r_ack1  <= 1'b0;
            r_ack2  <= 1'b0;
            r_grant <= 2'b00;
            r_ptr   <= r_grant[0];
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_o   = r_grant;
  assign bus.req_out_o = r_req_out;
  assign bus.ack_in1_o = r_ack1;
  assign bus.ack_in2_o = r_ack2;
  assign bus.busy_o    = r_busy;

endmodule

// File: tb/tb_hs_arbiter2.sv
// Bench for hs_arbiter2: one instance with a two-flop synchroniser (A) and one
// with direct sampling (B). A scoreboard queue holds the grant codes expected
// on A and a monitor pops one each time grant_o leaves 2'b00.
module tb_hs_arbiter2;

  localparam int RESP = 3;

  typedef struct {
    string       name;
    int          n1;
    int          n2;
    int          nexp;
    logic [11:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   rem1;
  int   rem2;
  int   rcnt;
  logic [1:0] exp_q [$];

  hs_arbiter2_if bus_a ();
  hs_arbiter2_if bus_b ();

  hs_arbiter2 #(.SYNC_STAGES(2)) u_dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  hs_arbiter2 #(.SYNC_STAGES(0)) u_dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  function automatic logic get_sig(input int dut, input int id);
    logic [4:0] v;
    if (dut == 0)
      v = {(bus_a.grant_o != 2'b00), bus_a.req_out_o, bus_a.ack_in1_o, bus_a.ack_in2_o, bus_a.busy_o};
    else
      v = {(bus_b.grant_o != 2'b00), bus_b.req_out_o, bus_b.ack_in1_o, bus_b.ack_in2_o, bus_b.busy_o};
    return v[4-id];
  endfunction

  // ids: 0 grant nonzero, 1 req_out, 2 ack_in1, 3 ack_in2, 4 busy
  task automatic wait_sig(input int dut, input int id, input logic val, output int n);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n++;
      if (get_sig(dut, id) == val) return;
    end
    n = -1;
  endtask

  // Client and resource model for instance A, advanced once per negedge
  task automatic env_step();
    if (bus_a.req_in1_i) begin
      if (bus_a.ack_in1_o) begin bus_a.req_in1_i = 1'b0; rem1--; end
    end else if (!bus_a.ack_in1_o && rem1 > 0) begin
      bus_a.req_in1_i = 1'b1;
    end
    if (bus_a.req_in2_i) begin
      if (bus_a.ack_in2_o) begin bus_a.req_in2_i = 1'b0; rem2--; end
    end else if (!bus_a.ack_in2_o && rem2 > 0) begin
      bus_a.req_in2_i = 1'b1;
    end
    if (bus_a.req_out_o != bus_a.ack_out_i) begin
      rcnt++;
      if (rcnt >= RESP) begin bus_a.ack_out_i = bus_a.req_out_o; rcnt = 0; end
    end else begin
      rcnt = 0;
    end
  endtask

  task automatic run_until_done(input string name);
    int cyc;
    bit done;
    done = 1'b0;
    rcnt = 0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      env_step();
      done = (rem1 == 0) && (rem2 == 0) && !bus_a.req_in1_i && !bus_a.req_in2_i &&
             !bus_a.busy_o && (bus_a.grant_o == 2'b00) && !bus_a.ack_out_i;
    end
    chk({name, "_done"}, int'(done), 1);
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Scoreboard monitor on instance A plus per-cycle output invariants
  initial begin
    logic [1:0] prev;
    logic [1:0] e;
    logic [1:0] g;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      g = bus_a.grant_o;
      if (g != prev) begin
        checks++;
        if (g == 2'b11 || (prev != 2'b00 && g != 2'b00)) begin
          errors++;
          $display("FAIL grant_switch actual %b required via 00 from %b", g, prev);
        end
        if (prev == 2'b00) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected actual %b required none", g);
          end else begin
            e = exp_q.pop_front();
            if (e != g) begin
              errors++;
              $display("FAIL grant_order actual %b required %b", g, e);
            end else begin
              $display("ok   grant_order = %b", g);
            end
          end
        end
        prev = g;
      end
      checks++;
      if ((g == 2'b01 && bus_a.ack_in2_o) || (g == 2'b10 && bus_a.ack_in1_o) ||
          (g == 2'b00 && (bus_a.ack_in1_o || bus_a.ack_in2_o || bus_a.req_out_o)) ||
          (bus_a.busy_o != (g != 2'b00))) begin
        errors++;
        $display("FAIL invariant actual g=%b a1=%b a2=%b ro=%b busy=%b required loser quiet, busy==|grant",
                 g, bus_a.ack_in1_o, bus_a.ack_in2_o, bus_a.req_out_o, bus_a.busy_o);
      end
    end
  end

  initial begin
    vec_t vecs [5];
    int   n;

    vecs[0] = '{name: "single1",    n1: 1, n2: 0, nexp: 1, exp: 12'b0000_0000_0001};
    vecs[1] = '{name: "single2",    n1: 0, n2: 1, nexp: 1, exp: 12'b0000_0000_0010};
    vecs[2] = '{name: "both",       n1: 1, n2: 1, nexp: 2, exp: 12'b0000_0000_1001};
    vecs[3] = '{name: "both_again", n1: 1, n2: 1, nexp: 2, exp: 12'b0000_0000_1001};
    vecs[4] = '{name: "alt6",       n1: 3, n2: 3, nexp: 6, exp: 12'b1001_1001_1001};

    checks = 0;
    errors = 0;
    rem1 = 0;
    rem2 = 0;
    rcnt = 0;
    rst_n = 1'b0;
    bus_a.req_in1_i = 1'b0; bus_a.req_in2_i = 1'b0; bus_a.ack_out_i = 1'b0;
    bus_b.req_in1_i = 1'b0; bus_b.req_in2_i = 1'b0; bus_b.ack_out_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs_a", int'({bus_a.grant_o, bus_a.req_out_o, bus_a.ack_in1_o, bus_a.ack_in2_o, bus_a.busy_o}), 0);
    chk("rst_outs_b", int'({bus_b.grant_o, bus_b.req_out_o, bus_b.ack_in1_o, bus_b.ack_in2_o, bus_b.busy_o}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single client on A: latency of each phase with two sync stages
    exp_q.push_back(2'b01);
    bus_a.req_in1_i = 1'b1;
    wait_sig(0, 0, 1'b1, n); chk("a_grant_lat", n, 3);
    chk("a_grant_code", int'(bus_a.grant_o), 1);
    wait_sig(0, 1, 1'b1, n); chk("a_reqout_lat", n, 1);
    repeat (RESP) @(negedge clk);
    bus_a.ack_out_i = 1'b1;
    wait_sig(0, 2, 1'b1, n); chk("a_ack1_rise_lat", n, 3);
    chk("a_ack2_quiet", int'(bus_a.ack_in2_o), 0);
    chk("a_busy_mid", int'(bus_a.busy_o), 1);
    bus_a.req_in1_i = 1'b0;
    wait_sig(0, 1, 1'b0, n); chk("a_reqout_fall_lat", n, 3);
    repeat (RESP) @(negedge clk);
    bus_a.ack_out_i = 1'b0;
    wait_sig(0, 2, 1'b0, n); chk("a_ack1_fall_lat", n, 3);
    chk("a_end_busy", int'(bus_a.busy_o), 0);
    chk("a_end_grant", int'(bus_a.grant_o), 0);
    chk("a_sb_empty_1", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    // Table of client workloads on A; expected grant order goes to the scoreboard
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].nexp; i++) exp_q.push_back(vecs[v].exp[2*i +: 2]);
      rem1 = vecs[v].n1;
      rem2 = vecs[v].n2;
      run_until_done(vecs[v].name);
      repeat (2) @(negedge clk);
    end

    // Reset while in HOLD, with the request still pending afterwards
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    bus_a.req_in1_i = 1'b1;
    wait_sig(0, 1, 1'b1, n);
    bus_a.ack_out_i = 1'b1;
    wait_sig(0, 2, 1'b1, n); chk("hold_reached", n, 3);
    rst_n = 1'b0;
    bus_a.ack_out_i = 1'b0;
    #1;
    chk("rst_async_outs", int'({bus_a.grant_o, bus_a.req_out_o, bus_a.ack_in1_o, bus_a.ack_in2_o, bus_a.busy_o}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 0, 1'b1, n); chk("regrant_lat", n, 3);
    rem1 = 1;
    rem2 = 0;
    run_until_done("after_reset");
    repeat (2) @(negedge clk);

    // Direct sampling on B: each response one edge after its input
    bus_b.req_in1_i = 1'b1;
    wait_sig(1, 0, 1'b1, n); chk("b_grant_lat", n, 1);
    chk("b_grant_code", int'(bus_b.grant_o), 1);
    wait_sig(1, 1, 1'b1, n); chk("b_reqout_lat", n, 1);
    bus_b.ack_out_i = 1'b1;
    wait_sig(1, 2, 1'b1, n); chk("b_ack1_rise_lat", n, 1);
    bus_b.req_in1_i = 1'b0;
    wait_sig(1, 1, 1'b0, n); chk("b_reqout_fall_lat", n, 1);
    bus_b.ack_out_i = 1'b0;
    wait_sig(1, 2, 1'b0, n); chk("b_ack1_fall_lat", n, 1);
    chk("b_end_idle", int'({bus_b.grant_o, bus_b.busy_o}), 0);
    repeat (2) @(negedge clk);

    // Client 2 on B drops its request while the arbiter waits in REQ
    bus_b.req_in2_i = 1'b1;
    wait_sig(1, 0, 1'b1, n); chk("b2_grant_lat", n, 1);
    chk("b2_grant_code", int'(bus_b.grant_o), 2);
    wait_sig(1, 1, 1'b1, n); chk("b2_reqout_lat", n, 1);
    bus_b.req_in2_i = 1'b0;
    @(negedge clk);
    bus_b.ack_out_i = 1'b1;
    wait_sig(1, 3, 1'b1, n); chk("b2_ack2_rise_lat", n, 1);
    chk("b2_ack1_quiet", int'(bus_b.ack_in1_o), 0);
    wait_sig(1, 1, 1'b0, n); chk("b2_hold_len", n, 1);
    bus_b.ack_out_i = 1'b0;
    wait_sig(1, 3, 1'b0, n); chk("b2_ack2_fall_lat", n, 1);
    chk("b2_end_idle", int'({bus_b.grant_o, bus_b.busy_o, bus_b.req_out_o}), 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
